// File: rtl/ss_pkg.sv
// Shared constants for the seven-segment display path: glyph table, idle codes
// and the capture FSM state type.
package ss_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] DRV_IDLE  = 8'hFF;

  // Active-high gfedcba, indexed by the 4-bit code (0-9, A, b, C, d, E, F).
  localparam logic [6:0] SS_GLYPH [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } ss_state_e;
endpackage

// File: rtl/ss_glyph_lookup.sv
// Reverse glyph lookup: active-high gfedcba pattern to {hit, code}.
module ss_glyph_lookup
  import ss_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic       o_hit,
  output logic [3:0] o_code
);
  always_comb begin
    o_hit  = 1'b0;
    o_code = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (i_pattern == SS_GLYPH[i]) begin
        o_hit  = 1'b1;
        o_code = 4'(i);
      end
    end
  end
endmodule

// File: rtl/ss_capture.sv
// Seven-segment display monitor: demultiplexes the digit windows, debounces the
// lit pattern within each window and decodes it back to a 4-bit code per digit.
//   state   | meaning
//   ST_IDLE | no digit selected; waiting for a legal window
//   ST_OPEN | window of digit r_k open; accumulating lit samples
module ss_capture
  import ss_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] SegmentDrivers,
  input  logic [7:0] SevenSegment,
  output logic [3:0] BCD0,
  output logic [3:0] BCD1,
  output logic [3:0] BCD2,
  output logic [3:0] BCD3,
  output logic [3:0] DigitValid,
  output logic [3:0] Dp,
  output logic       FrameDone,
  output logic       SegError,
  output logic       DrvError
);
  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [7:0]       r_drv_q, r_seg_q;
  ss_state_e        r_state, w_state_nxt;
  logic [1:0]       r_k, w_k;
  logic [6:0]       r_cand, r_acc;
  logic [CNT_W-1:0] r_cnt, w_cnt_inc;
  logic             r_got, r_dp_acc;
  logic [3:0]       r_bcd [4];
  logic [3:0]       r_valid, r_dp;
  logic             r_frame_done, r_seg_err, r_drv_err;

  logic [3:0] w_low;
  logic       w_hi_ok, w_any_low, w_onehot, w_valid_win, w_illegal;
  logic       w_commit, w_open, w_sample, w_lit, w_hit;
  logic [3:0] w_code;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_drv_q <= DRV_IDLE;
      r_seg_q <= {1'b1, SEG_BLANK};
    end else begin
      r_drv_q <= SegmentDrivers;
      r_seg_q <= SevenSegment;
    end
  end

  assign w_low       = ~r_drv_q[3:0];
  assign w_hi_ok     = (r_drv_q[7:4] == 4'hF);
  assign w_any_low   = |w_low;
  assign w_onehot    = w_any_low && ((w_low & (w_low - 4'd1)) == 4'd0);
  assign w_valid_win = w_hi_ok && w_onehot;
  assign w_illegal   = w_any_low && !w_valid_win;

  always_comb begin
    w_k = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_low[i]) w_k = 2'(i);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_open      = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid_win) begin
          w_open      = 1'b1;
          w_state_nxt = ST_OPEN;
        end
      end
      ST_OPEN: begin
        if (w_valid_win && (w_k == r_k)) begin
          w_sample = 1'b1;
        end else begin
          w_commit = 1'b1;
          if (w_valid_win) w_open = 1'b1;
          else             w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_lit     = (r_seg_q[6:0] != SEG_BLANK);
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  // Blank samples leave the stability run untouched so PWM gaps are tolerated.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_k      <= 2'd0;
      r_cand   <= 7'h00;
      r_acc    <= 7'h00;
      r_cnt    <= '0;
      r_got    <= 1'b0;
      r_dp_acc <= 1'b0;
    end else if (w_open) begin
      r_k      <= w_k;
      r_cand   <= 7'h00;
      r_cnt    <= '0;
      r_got    <= 1'b0;
      r_dp_acc <= 1'b0;
    end else if (w_sample && w_lit) begin
      if (r_seg_q[6:0] == r_cand) begin
        r_cnt <= w_cnt_inc;
        if (w_cnt_inc == CNT_MAX) begin
          r_acc <= r_cand;
          r_got <= 1'b1;
        end
      end else begin
        r_cand <= r_seg_q[6:0];
        r_cnt  <= CNT_W'(1);
        if (CNT_MAX == CNT_W'(1)) begin
          r_acc <= r_seg_q[6:0];
          r_got <= 1'b1;
        end
      end
      if (!r_seg_q[7]) r_dp_acc <= 1'b1;
    end
  end

  ss_glyph_lookup u_lookup (
    .i_pattern (~r_acc),
    .o_hit     (w_hit),
    .o_code    (w_code)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) r_bcd[i] <= 4'h0;
      r_valid      <= 4'h0;
      r_dp         <= 4'h0;
      r_frame_done <= 1'b0;
      r_seg_err    <= 1'b0;
      r_drv_err    <= 1'b0;
    end else begin
      r_frame_done <= w_commit && (r_k == 2'd3);
      r_seg_err    <= w_commit && r_got && !w_hit;
      r_drv_err    <= w_illegal;
      if (w_commit) begin
        r_dp[r_k]    <= r_dp_acc;
        r_valid[r_k] <= r_got && w_hit;
        if (r_got && w_hit) r_bcd[r_k] <= w_code;
      end
    end
  end

  assign BCD0       = r_bcd[0];
  assign BCD1       = r_bcd[1];
  assign BCD2       = r_bcd[2];
  assign BCD3       = r_bcd[3];
  assign DigitValid = r_valid;
  assign Dp         = r_dp;
  assign FrameDone  = r_frame_done;
  assign SegError   = r_seg_err;
  assign DrvError   = r_drv_err;
endmodule

// File: tb/tb_ss_capture.sv
// Self-checking bench for ss_capture: vector table, corner sequences and a
// randomized window stream checked against a per-window reference model.
module tb_ss_capture;
  localparam int STABLE = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] SegmentDrivers;
  logic [7:0] SevenSegment;
  logic [3:0] BCD0, BCD1, BCD2, BCD3;
  logic [3:0] DigitValid, Dp;
  logic       FrameDone, SegError, DrvError;

  ss_capture #(.STABLE_CYCLES(STABLE)) dut (
    .Clk(Clk), .Reset(Reset),
    .SegmentDrivers(SegmentDrivers), .SevenSegment(SevenSegment),
    .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3),
    .DigitValid(DigitValid), .Dp(Dp),
    .FrameDone(FrameDone), .SegError(SegError), .DrvError(DrvError)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_fail = 0;
  int fd_cnt = 0, se_cnt = 0, de_cnt = 0;

  always @(negedge Clk) begin
    if (FrameDone) fd_cnt++;
    if (SegError)  se_cnt++;
    if (DrvError)  de_cnt++;
  end

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    int         k;
    logic [7:0] seg;
    int         len;
    int         every;
    logic       v;
    logic [3:0] b;
    logic       dp;
    int         se;
  } vec_t;
  vec_t tbl [11];

  // reference state for the randomized stream
  logic [3:0] exp_bcd [4];
  logic [3:0] exp_valid, exp_dp;
  int         exp_fd, exp_se;
  int         fd_base, se_base, de_base;
  logic [7:0] win_q [$];
  logic [7:0] last_seg;
  bit         pending;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] drv, input logic [7:0] seg);
    SegmentDrivers = drv;
    SevenSegment   = seg;
    tick();
  endtask

  function automatic logic [7:0] drv_of(input int k);
    logic [3:0] m;
    m = 4'hF;
    m[k] = 1'b0;
    return {4'hF, m};
  endfunction

  function automatic logic [3:0] bcd_of(input int k);
    logic [15:0] w;
    w = {BCD3, BCD2, BCD1, BCD0};
    return w[k*4 +: 4];
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'hFF, 8'hFF);
  endtask

  task automatic window(input int k, input logic [7:0] seg, input int len);
    for (int i = 0; i < len; i++) drive(drv_of(k), seg);
  endtask

  // Expected commit: the decoded value is the last run of >= STABLE identical
  // lit samples (blanks removed); the opening cycle of a window is never sampled.
  task automatic model_commit(input int k);
    logic [6:0] lit [$];
    logic       dp, got, found;
    logic [6:0] acc;
    logic [3:0] code;
    int         run;
    dp = 1'b0; got = 1'b0; found = 1'b0; acc = 7'h00; code = 4'h0; run = 0;
    foreach (win_q[i]) begin
      if (win_q[i][6:0] != 7'h7F) begin
        lit.push_back(win_q[i][6:0]);
        if (!win_q[i][7]) dp = 1'b1;
      end
    end
    for (int i = 0; i < lit.size(); i++) begin
      run = (i > 0 && lit[i] == lit[i-1]) ? run + 1 : 1;
      if (run >= STABLE) begin
        got = 1'b1;
        acc = lit[i];
      end
    end
    for (int c = 0; c < 16; c++) begin
      if (glyph[c] == ~acc) begin
        found = 1'b1;
        code = 4'(c);
      end
    end
    exp_dp[k] = dp;
    exp_valid[k] = got && found;
    if (got && found) exp_bcd[k] = code;
    if (got && !found) exp_se++;
    if (k == 3) exp_fd++;
  endtask

  task automatic check_all(input string nm);
    chk({nm, "_bcd"}, {BCD3, BCD2, BCD1, BCD0}, {exp_bcd[3], exp_bcd[2], exp_bcd[1], exp_bcd[0]});
    chk({nm, "_valid"}, DigitValid, exp_valid);
    chk({nm, "_dp"}, Dp, exp_dp);
    chk({nm, "_framedone"}, fd_cnt - fd_base, exp_fd);
    chk({nm, "_segerr"}, se_cnt - se_base, exp_se);
    chk({nm, "_drverr"}, de_cnt - de_base, 0);
  endtask

  task automatic gen_seg(output logic [7:0] s);
    int r;
    int c;
    r = $urandom_range(0, 99);
    if (r < 65) s = last_seg;
    else if (r < 78) s = {($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1, 7'h7F};
    else if (r < 84) s = 8'hFE;
    else begin
      c = $urandom_range(0, 15);
      s = {($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1, ~glyph[c]};
    end
    last_seg = s;
  endtask

  task automatic run_segment(input int k, input bit is_win, input int len);
    logic [7:0] s;
    win_q.delete();
    for (int c = 0; c < len; c++) begin
      if (is_win) gen_seg(s);
      else s = 8'hFF;
      if (c > 0) win_q.push_back(s);
      drive(is_win ? drv_of(k) : 8'hFF, s);
      if (c == 2 && pending) begin
        check_all("rnd");
        pending = 1'b0;
      end
    end
    if (is_win) begin
      model_commit(k);
      pending = 1'b1;
    end
  endtask

  initial begin
    int fd0, se0, de0, prev_k, k;

    //            k  seg    len every v     bcd   dp    se
    tbl[0]  = '{0, 8'hC0, 10, 1,  1'b1, 4'h0, 1'b0, 0};
    tbl[1]  = '{1, 8'h24, 10, 1,  1'b1, 4'h2, 1'b1, 0};
    tbl[2]  = '{0, 8'h12, 40, 2,  1'b1, 4'h5, 1'b1, 0};
    tbl[3]  = '{3, 8'h80, 5,  1,  1'b1, 4'h8, 1'b0, 0};
    tbl[4]  = '{3, 8'h80, 4,  1,  1'b0, 4'h8, 1'b0, 0};
    tbl[5]  = '{2, 8'hB0, 10, 1,  1'b1, 4'h3, 1'b0, 0};
    tbl[6]  = '{2, 8'hFE, 10, 1,  1'b0, 4'h3, 1'b0, 1};
    tbl[7]  = '{0, 8'h0E, 8,  1,  1'b1, 4'hF, 1'b1, 0};
    tbl[8]  = '{1, 8'hA1, 40, 13, 1'b0, 4'h2, 1'b0, 0};
    tbl[9]  = '{1, 8'h7F, 10, 1,  1'b0, 4'h2, 1'b0, 0};
    tbl[10] = '{0, 8'h88, 6,  1,  1'b1, 4'hA, 1'b0, 0};

    Reset = 1'b1;
    idle(3);
    chk("reset_bcd", {BCD3, BCD2, BCD1, BCD0}, 16'h0000);
    chk("reset_valid", DigitValid, 4'h0);
    chk("reset_dp", Dp, 4'h0);
    chk("reset_pulses", {FrameDone, SegError, DrvError}, 3'b000);
    Reset = 1'b0;
    idle(2);

    foreach (tbl[r]) begin
      fd0 = fd_cnt; se0 = se_cnt; de0 = de_cnt;
      for (int i = 0; i < tbl[r].len; i++)
        drive(drv_of(tbl[r].k), (i % tbl[r].every == 0) ? tbl[r].seg : 8'h7F);
      idle(3);
      chk($sformatf("tbl%0d_bcd", r), bcd_of(tbl[r].k), tbl[r].b);
      chk($sformatf("tbl%0d_valid", r), DigitValid[tbl[r].k], tbl[r].v);
      chk($sformatf("tbl%0d_dp", r), Dp[tbl[r].k], tbl[r].dp);
      chk($sformatf("tbl%0d_segerr", r), se_cnt - se0, tbl[r].se);
      chk($sformatf("tbl%0d_framedone", r), fd_cnt - fd0, (tbl[r].k == 3) ? 1 : 0);
      chk($sformatf("tbl%0d_drverr", r), de_cnt - de0, 0);
    end

    // full frame, back-to-back windows
    fd0 = fd_cnt;
    window(0, 8'h79, 100);
    window(1, 8'h24, 100);
    window(2, 8'h30, 100);
    window(3, 8'h19, 100);
    idle(3);
    chk("frame_bcd", {BCD3, BCD2, BCD1, BCD0}, 16'h4321);
    chk("frame_valid", DigitValid, 4'hF);
    chk("frame_dp", Dp, 4'hF);
    chk("frame_framedone", fd_cnt - fd0, 1);

    // illegal drive closes an open window
    fd0 = fd_cnt; se0 = se_cnt; de0 = de_cnt;
    window(0, 8'hC0, 20);
    drive(8'hF5, 8'hC0);
    idle(3);
    chk("drv_err_pulse", de_cnt - de0, 1);
    chk("drv_commit_bcd", {BCD3, BCD2, BCD1, BCD0}, 16'h4320);
    chk("drv_commit_valid", DigitValid, 4'hF);
    drive(8'h7E, 8'hC0);
    idle(3);
    chk("drv_err_hi_nibble", de_cnt - de0, 2);
    drive(8'h7F, 8'hC0);
    idle(3);
    chk("drv_alloff_not_err", de_cnt - de0, 2);
    chk("drv_no_commit_bcd", {BCD3, BCD2, BCD1, BCD0}, 16'h4320);
    chk("drv_no_framedone", fd_cnt - fd0, 0);

    // reset mid-window discards the window
    fd0 = fd_cnt;
    window(3, 8'h00, 20);
    SegmentDrivers = drv_of(3);
    Reset = 1'b1;
    tick();
    chk("rst_mid_bcd", {BCD3, BCD2, BCD1, BCD0}, 16'h0000);
    chk("rst_mid_valid", DigitValid, 4'h0);
    chk("rst_mid_dp", Dp, 4'h0);
    Reset = 1'b0;
    idle(3);
    chk("rst_mid_no_framedone", fd_cnt - fd0, 0);
    chk("rst_mid_still_zero", {DigitValid, Dp, BCD3}, 12'h000);
    window(3, 8'h00, 20);
    idle(3);
    chk("rst_after_bcd3", BCD3, 4'h8);
    chk("rst_after_valid", DigitValid, 4'h8);
    chk("rst_after_dp", Dp, 4'h8);
    chk("rst_after_framedone", fd_cnt - fd0, 1);

    // randomized window stream against the reference model
    Reset = 1'b1;
    idle(1);
    Reset = 1'b0;
    idle(2);
    for (int i = 0; i < 4; i++) exp_bcd[i] = 4'h0;
    exp_valid = 4'h0; exp_dp = 4'h0; exp_fd = 0; exp_se = 0;
    fd_base = fd_cnt; se_base = se_cnt; de_base = de_cnt;
    last_seg = 8'hC0;
    pending = 1'b0;
    prev_k = -1;
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 3);
      if (k == prev_k || $urandom_range(0, 4) == 0)
        run_segment(0, 1'b0, $urandom_range(3, 6));
      run_segment(k, 1'b1, $urandom_range(3, 30));
      prev_k = k;
    end
    run_segment(0, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
